// File: rtl/lvds_tx_arbiter_if.sv
// lvds_tx_arbiter_if -- requester and serializer handshake bundle for the
// LVDS transmit arbiter.
//
// Signals:
//   req_data_k  [28:0]  requester k payload
//   req_EN_k            requester k enqueue strobe
//   req_RDY_k           requester k slot free
//   enq_tx      [31:0]  word offered to the serializer ({valid, src_id, data})
//   RDY_enq_tx          enq_tx valid and may be taken
//   EN_enq_tx           serializer take strobe
//
// Modports: master = requesters + serializer side, slave = arbiter side.
interface lvds_tx_arbiter_if;
  logic [28:0] req_data_0;
  logic [28:0] req_data_1;
  logic [28:0] req_data_2;
  logic [28:0] req_data_3;
  logic        req_EN_0;
  logic        req_EN_1;
  logic        req_EN_2;
  logic        req_EN_3;
  logic        req_RDY_0;
  logic        req_RDY_1;
  logic        req_RDY_2;
  logic        req_RDY_3;
  logic [31:0] enq_tx;
  logic        RDY_enq_tx;
  logic        EN_enq_tx;

  modport master (
    output req_data_0, req_data_1, req_data_2, req_data_3,
    output req_EN_0, req_EN_1, req_EN_2, req_EN_3,
    output EN_enq_tx,
    input  req_RDY_0, req_RDY_1, req_RDY_2, req_RDY_3,
    input  enq_tx, RDY_enq_tx
  );

  modport slave (
    input  req_data_0, req_data_1, req_data_2, req_data_3,
    input  req_EN_0, req_EN_1, req_EN_2, req_EN_3,
    input  EN_enq_tx,
    output req_RDY_0, req_RDY_1, req_RDY_2, req_RDY_3,
    output enq_tx, RDY_enq_tx
  );
endinterface

// File: rtl/lvds_tx_arbiter.sv
// lvds_tx_arbiter -- four one-entry request slots arbitrated round-robin onto
// a single output register that feeds the LVDS serializer.
//
// Ports:
//   tx_inclock  sole clock, rising edge
//   reset_n     synchronous active-low reset
//   link_up     PLL locked and far end ready; gates grants and RDY_enq_tx
//   bus         lvds_tx_arbiter_if.slave (requester slots + serializer handshake)
//   word_count  accepted-word counter, wraps modulo 2^16
//   stall       offered word has waited STALL_LIMIT or more cycles
//   overflow    sticky per-requester write-while-full flags
module lvds_tx_arbiter #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic               tx_inclock,
  input  logic               reset_n,
  input  logic               link_up,
  lvds_tx_arbiter_if.slave   bus,
  output logic [15:0]        word_count,
  output logic               stall,
  output logic [3:0]         overflow
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Stall counter is at least 8 bits and grows if the limit needs more.
  localparam int unsigned         STALL_W      = (STALL_LIMIT > 255) ? $clog2(STALL_LIMIT + 1) : 8;
  localparam logic [STALL_W-1:0]  STALL_THRESH = STALL_W'(STALL_LIMIT);

  logic [3:0]         req_en;
  logic [28:0]        req_data [4];
  state_t             state, state_next;
  logic [1:0]         ptr;
  logic [3:0]         full;
  logic [28:0]        slot_data [4];
  logic [31:0]        out_word;
  logic [15:0]        word_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic               any_full;
  logic [1:0]         grant_idx;
  logic [1:0]         cand;
  logic               grant;
  logic               rdy;
  logic               accept;

  assign req_en      = {bus.req_EN_3, bus.req_EN_2, bus.req_EN_1, bus.req_EN_0};
  assign req_data[0] = bus.req_data_0;
  assign req_data[1] = bus.req_data_1;
  assign req_data[2] = bus.req_data_2;
  assign req_data[3] = bus.req_data_3;

  assign rdy    = (state == HOLD) && link_up;
  assign accept = rdy && bus.EN_enq_tx;

  // First full slot at or after ptr, wrapping modulo 4.
  always_comb begin : pick
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    any_full  = 1'b0;
    grant_idx = ptr;
    cand      = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!any_full && full[cand]) begin
        any_full  = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_next = state;
    grant      = 1'b0;
    case (state)
      IDLE: if (link_up && any_full) begin
        grant      = 1'b1;
        state_next = HOLD;
      end
      HOLD: if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge tx_inclock) begin : fsm_reg
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge tx_inclock) begin : out_reg
    if (!reset_n) begin
      ptr      <= 2'd0;
      out_word <= 32'h0;
    end else if (grant) begin
      ptr      <= grant_idx + 2'd1;
      out_word <= {1'b1, grant_idx, slot_data[grant_idx]};
    end
  end

  // A write to a full slot (including one being granted this cycle) is
  // dropped and flagged; the grant still empties the slot.
  always_ff @(posedge tx_inclock) begin : slot_ctrl
    if (!reset_n) begin
      full     <= 4'h0;
      overflow <= 4'h0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (req_en[k] && full[k]) overflow[k] <= 1'b1;
        if (req_en[k] && !full[k])               full[k] <= 1'b1;
        else if (grant && grant_idx == 2'(k))    full[k] <= 1'b0;
      end
    end
  end

  // NOTE: slot payloads are not reset; full[] alone decides whether they are meaningful.
  always_ff @(posedge tx_inclock) begin : slot_store
    for (int k = 0; k < 4; k++) begin
      if (req_en[k] && !full[k]) slot_data[k] <= req_data[k];
    end
  end

  always_ff @(posedge tx_inclock) begin : count_reg
    if (!reset_n)    word_cnt <= 16'h0;
    else if (accept) word_cnt <= word_cnt + 16'd1;
  end

  // Counts cycles the word is offered but not taken; holds while link is down.
  always_ff @(posedge tx_inclock) begin : stall_reg
    if (!reset_n || state == IDLE || accept) stall_cnt <= '0;
    else if (rdy && stall_cnt != '1)         stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall          = (stall_cnt >= STALL_THRESH);
  assign word_count     = word_cnt;
  assign bus.enq_tx     = (state == HOLD) ? out_word : 32'h0;
  assign bus.RDY_enq_tx = rdy;
  assign bus.req_RDY_0  = ~full[0];
  assign bus.req_RDY_1  = ~full[1];
  assign bus.req_RDY_2  = ~full[2];
  assign bus.req_RDY_3  = ~full[3];

endmodule

// File: tb/tb_lvds_tx_arbiter.sv
// tb_lvds_tx_arbiter -- directed bench for lvds_tx_arbiter with STALL_LIMIT=4.
// Inputs change 2 ns after the rising edge; outputs are compared there too.
module tb_lvds_tx_arbiter;
  localparam int unsigned STALL_LIMIT = 4;

  logic        tx_inclock = 1'b0;
  logic        reset_n    = 1'b0;
  logic        link_up    = 1'b0;
  logic [15:0] word_count;
  logic        stall;
  logic [3:0]  overflow;
  logic [3:0]  req_rdy;
  int          passed = 0;
  int          total  = 0;

  lvds_tx_arbiter_if bus ();

  lvds_tx_arbiter #(.STALL_LIMIT(STALL_LIMIT)) dut (
    .tx_inclock (tx_inclock),
    .reset_n    (reset_n),
    .link_up    (link_up),
    .bus        (bus.slave),
    .word_count (word_count),
    .stall      (stall),
    .overflow   (overflow)
  );

  always #5 tx_inclock = ~tx_inclock;

  assign req_rdy = {bus.req_RDY_3, bus.req_RDY_2, bus.req_RDY_1, bus.req_RDY_0};

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge tx_inclock);
      #2;
    end
  endtask

  task automatic drive_req(input int k, input logic [28:0] d);
    case (k)
      0: begin bus.req_EN_0 = 1'b1; bus.req_data_0 = d; end
      1: begin bus.req_EN_1 = 1'b1; bus.req_data_1 = d; end
      2: begin bus.req_EN_2 = 1'b1; bus.req_data_2 = d; end
      default: begin bus.req_EN_3 = 1'b1; bus.req_data_3 = d; end
    endcase
  endtask

  task automatic clear_req();
    bus.req_EN_0 = 1'b0;
    bus.req_EN_1 = 1'b0;
    bus.req_EN_2 = 1'b0;
    bus.req_EN_3 = 1'b0;
  endtask

  task automatic accept_word();
    bus.EN_enq_tx = 1'b1;
    tick();
    bus.EN_enq_tx = 1'b0;
  endtask

  // Reset held with requests and a take strobe active; reset must win.
  task automatic test_reset();
    reset_n = 1'b0;
    link_up = 1'b1;
    drive_req(0, 29'h0000001);
    bus.EN_enq_tx = 1'b1;
    tick(2);
    total++; if (bus.RDY_enq_tx !== 1'b0) $display("FAIL reset_rdy: got %b want 0", bus.RDY_enq_tx); else passed++;
    total++; if (bus.enq_tx !== 32'h0) $display("FAIL reset_enq: got %h want 00000000", bus.enq_tx); else passed++;
    total++; if (req_rdy !== 4'hF) $display("FAIL reset_req_rdy: got %b want 1111", req_rdy); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
    total++; if (word_count !== 16'h0) $display("FAIL reset_count: got %h want 0000", word_count); else passed++;
    total++; if (overflow !== 4'h0) $display("FAIL reset_overflow: got %b want 0000", overflow); else passed++;
    clear_req();
    bus.EN_enq_tx = 1'b0;
    reset_n = 1'b1;
    tick();
    total++; if (req_rdy !== 4'hF) $display("FAIL reset_release_req_rdy: got %b want 1111", req_rdy); else passed++;
    total++; if (bus.RDY_enq_tx !== 1'b0) $display("FAIL reset_release_rdy: got %b want 0", bus.RDY_enq_tx); else passed++;
  endtask

  task automatic test_single_word();
    link_up = 1'b1;
    drive_req(2, 29'h0ABCDEF);
    tick();
    clear_req();
    total++; if (req_rdy !== 4'b1011) $display("FAIL single_slot_full: got %b want 1011", req_rdy); else passed++;
    total++; if (bus.RDY_enq_tx !== 1'b0) $display("FAIL single_rdy_early: got %b want 0", bus.RDY_enq_tx); else passed++;
    tick();
    total++; if (bus.RDY_enq_tx !== 1'b1) $display("FAIL single_rdy: got %b want 1", bus.RDY_enq_tx); else passed++;
    total++; if (bus.enq_tx !== 32'hC0ABCDEF) $display("FAIL single_enq: got %h want c0abcdef", bus.enq_tx); else passed++;
    total++; if (req_rdy !== 4'hF) $display("FAIL single_slot_freed: got %b want 1111", req_rdy); else passed++;
    accept_word();
    total++; if (bus.RDY_enq_tx !== 1'b0) $display("FAIL single_rdy_after: got %b want 0", bus.RDY_enq_tx); else passed++;
    total++; if (bus.enq_tx !== 32'h0) $display("FAIL single_enq_idle: got %h want 00000000", bus.enq_tx); else passed++;
    total++; if (word_count !== 16'd1) $display("FAIL single_count: got %0d want 1", word_count); else passed++;
  endtask

  // Two rounds of all four slots, serializer taking one word per 8 cycles.
  task automatic test_round_robin();
    logic [28:0] d;
    logic [31:0] exp;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    link_up = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) drive_req(k, 29'(32'h100 * (r + 1) + k));
      tick();
      clear_req();
      for (int w = 0; w < 4; w++) begin
        tick();
        d   = 29'(32'h100 * (r + 1) + w);
        exp = {1'b1, 2'(w), d};
        total++; if (bus.RDY_enq_tx !== 1'b1) $display("FAIL rr_rdy r%0d w%0d: got %b want 1", r, w, bus.RDY_enq_tx); else passed++;
        total++; if (bus.enq_tx !== exp) $display("FAIL rr_word r%0d w%0d: got %h want %h", r, w, bus.enq_tx, exp); else passed++;
        tick(7);
        total++; if (stall !== 1'b1) $display("FAIL rr_stall r%0d w%0d: got %b want 1", r, w, stall); else passed++;
        accept_word();
        total++; if (stall !== 1'b0) $display("FAIL rr_stall_clear r%0d w%0d: got %b want 0", r, w, stall); else passed++;
      end
    end
    total++; if (word_count !== 16'd8) $display("FAIL rr_count: got %0d want 8", word_count); else passed++;
  endtask

  task automatic test_overflow();
    link_up = 1'b0;
    drive_req(1, 29'h1111111);
    tick();
    drive_req(1, 29'h2222222);
    tick();
    clear_req();
    total++; if (overflow !== 4'b0010) $display("FAIL ovf_flag: got %b want 0010", overflow); else passed++;
    total++; if (req_rdy !== 4'b1101) $display("FAIL ovf_req_rdy: got %b want 1101", req_rdy); else passed++;
    total++; if (bus.RDY_enq_tx !== 1'b0) $display("FAIL ovf_link_down_rdy: got %b want 0", bus.RDY_enq_tx); else passed++;
    link_up = 1'b1;
    tick();
    total++; if (bus.enq_tx !== 32'hA1111111) $display("FAIL ovf_first_word: got %h want a1111111", bus.enq_tx); else passed++;
    accept_word();
    tick(2);
    total++; if (bus.RDY_enq_tx !== 1'b0) $display("FAIL ovf_no_second: got %b want 0", bus.RDY_enq_tx); else passed++;
    total++; if (word_count !== 16'd9) $display("FAIL ovf_count: got %0d want 9", word_count); else passed++;
    // Write to slot 3 in the very cycle it is granted.
    drive_req(3, 29'h0333333);
    tick();
    drive_req(3, 29'h0444444);
    tick();
    clear_req();
    total++; if (overflow !== 4'b1010) $display("FAIL ovf_grant_cycle: got %b want 1010", overflow); else passed++;
    total++; if (bus.enq_tx !== 32'hE0333333) $display("FAIL ovf_grant_word: got %h want e0333333", bus.enq_tx); else passed++;
    total++; if (req_rdy !== 4'hF) $display("FAIL ovf_grant_slot: got %b want 1111", req_rdy); else passed++;
    accept_word();
  endtask

  task automatic test_link_drop();
    int rdy_seen;
    link_up = 1'b1;
    drive_req(0, 29'h0123456);
    tick();
    clear_req();
    tick();
    link_up = 1'b0;
    bus.EN_enq_tx = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.RDY_enq_tx !== 1'b0) rdy_seen++;
    end
    bus.EN_enq_tx = 1'b0;
    total++; if (rdy_seen !== 0) $display("FAIL drop_rdy: got %0d rdy cycles want 0", rdy_seen); else passed++;
    total++; if (word_count !== 16'd10) $display("FAIL drop_count: got %0d want 10", word_count); else passed++;
    link_up = 1'b1;
    #1;
    total++; if (bus.RDY_enq_tx !== 1'b1) $display("FAIL drop_reoffer_rdy: got %b want 1", bus.RDY_enq_tx); else passed++;
    total++; if (bus.enq_tx !== 32'h80123456) $display("FAIL drop_reoffer_word: got %h want 80123456", bus.enq_tx); else passed++;
    accept_word();
    total++; if (word_count !== 16'd11) $display("FAIL drop_accept_count: got %0d want 11", word_count); else passed++;
  endtask

  // Stall threshold boundary and counter wrap from a preset 0xFFFF.
  task automatic test_stall_wrap();
    dut.word_cnt = 16'hFFFF;
    drive_req(2, 29'h0000055);
    tick();
    clear_req();
    tick();
    tick(3);
    total++; if (stall !== 1'b0) $display("FAIL stall_below: got %b want 0", stall); else passed++;
    tick();
    total++; if (stall !== 1'b1) $display("FAIL stall_at_limit: got %b want 1", stall); else passed++;
    accept_word();
    total++; if (stall !== 1'b0) $display("FAIL stall_after_accept: got %b want 0", stall); else passed++;
    total++; if (word_count !== 16'h0000) $display("FAIL count_wrap: got %h want 0000", word_count); else passed++;
  endtask

  task automatic test_reset_mid_hold();
    link_up = 1'b1;
    drive_req(1, 29'h0000011);
    tick();
    clear_req();
    tick();
    drive_req(2, 29'h0000022);
    drive_req(3, 29'h0000033);
    tick();
    clear_req();
    reset_n = 1'b0;
    drive_req(0, 29'h0000044);
    bus.EN_enq_tx = 1'b1;
    tick();
    reset_n = 1'b1;
    clear_req();
    bus.EN_enq_tx = 1'b0;
    total++; if (bus.RDY_enq_tx !== 1'b0) $display("FAIL midrst_rdy: got %b want 0", bus.RDY_enq_tx); else passed++;
    total++; if (bus.enq_tx !== 32'h0) $display("FAIL midrst_enq: got %h want 00000000", bus.enq_tx); else passed++;
    total++; if (req_rdy !== 4'hF) $display("FAIL midrst_req_rdy: got %b want 1111", req_rdy); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL midrst_stall: got %b want 0", stall); else passed++;
    total++; if (word_count !== 16'h0) $display("FAIL midrst_count: got %h want 0000", word_count); else passed++;
    total++; if (overflow !== 4'h0) $display("FAIL midrst_overflow: got %b want 0000", overflow); else passed++;
    drive_req(3, 29'h0000003);
    drive_req(0, 29'h0000000);
    tick();
    clear_req();
    tick();
    total++; if (bus.enq_tx !== 32'h80000000) $display("FAIL midrst_ptr_first: got %h want 80000000", bus.enq_tx); else passed++;
    accept_word();
    tick();
    total++; if (bus.enq_tx !== 32'hE0000003) $display("FAIL midrst_ptr_second: got %h want e0000003", bus.enq_tx); else passed++;
    accept_word();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    bus.req_data_0 = '0;
    bus.req_data_1 = '0;
    bus.req_data_2 = '0;
    bus.req_data_3 = '0;
    clear_req();
    bus.EN_enq_tx = 1'b0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_overflow();
    test_link_drop();
    test_stall_wrap();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lvds_tx_arbiter.md
LVDS_TX_ARBITER -- requirements
Module: lvds_tx_arbiter

Interface
REQ-001 The block SHALL have parameter STALL_LIMIT, default 255: consecutive unaccepted cycles before stall is flagged.
REQ-002 The block SHALL have port tx_inclock, input, 1: sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1: reset, synchronous, active-low, sampled on tx_inclock.
REQ-004 The block SHALL have port link_up, input, 1: TX PLL locked AND far end ready; gates grants and RDY_enq_tx.
REQ-005 The block SHALL have ports req_data_k, input, 29, for k=0..3: requester k payload.
REQ-006 The block SHALL have ports req_EN_k, input, 1, for k=0..3: requester k enqueue strobe.
REQ-007 The block SHALL have ports req_RDY_k, output, 1, for k=0..3: requester k slot free.
REQ-008 The block SHALL have port enq_tx, output, 32: word offered to the LVDS serializer.
REQ-009 The block SHALL have port RDY_enq_tx, output, 1: enq_tx valid and may be taken.
REQ-010 The block SHALL have port EN_enq_tx, input, 1: serializer take strobe, one cycle per word.
REQ-011 The block SHALL have port word_count, output, 16: accepted-word counter.
REQ-012 The block SHALL have port stall, output, 1: offered word held at or beyond STALL_LIMIT cycles.
REQ-013 The block SHALL have port overflow, output, 4: sticky per-requester write-while-full flag.

Function
REQ-014 Each requester k SHALL own a one-entry slot (full_k, data_k); req_RDY_k = ~full_k combinationally.
REQ-015 req_EN_k with req_RDY_k=1 SHALL capture req_data_k and set full_k at that edge.
REQ-016 req_EN_k with full_k=1 SHALL drop the data, leave data_k unchanged, and set overflow[k] until reset.
REQ-017 The FSM SHALL have two states: IDLE (output register empty) and HOLD (output register loaded).
REQ-018 In IDLE with link_up=1 and any full_k, the block SHALL grant the first full slot searching ptr, ptr+1, ... mod 4.
REQ-019 The grant SHALL, at one edge: load out_word = {1'b1, k[1:0], data_k}, clear full_k, set ptr = (k+1) mod 4, and enter HOLD.
REQ-020 With link_up=0, or with no full slot, IDLE SHALL hold; no grant, ptr unchanged.
REQ-021 enq_tx SHALL equal out_word in HOLD and 32'h0 in IDLE; bit 31 is the receiver's valid marker.
REQ-022 RDY_enq_tx SHALL equal (state==HOLD) AND link_up, combinationally.
REQ-023 EN_enq_tx with RDY_enq_tx=1 SHALL return the FSM to IDLE and increment word_count, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-024 EN_enq_tx with RDY_enq_tx=0 SHALL be ignored: no state change and no count.
REQ-025 Latency SHALL be: req_EN_k at edge N sets full_k; grant at edge N+1; RDY_enq_tx high after N+1 if link_up stays 1.
REQ-026 After an accept there SHALL be one IDLE cycle before the next grant, giving at most one word per 2 cycles; the serializer consumes one per 8.
REQ-027 A slot being granted SHALL show req_RDY_k=0 in the grant cycle; a req_EN_k in that cycle SHALL count as overflow.
REQ-028 If link_up falls in HOLD, out_word SHALL be retained and RDY_enq_tx SHALL drop; it SHALL re-offer when link_up returns.
REQ-029 stall_cnt (8-bit minimum, saturating) SHALL increment each HOLD cycle with RDY_enq_tx=1 and no EN_enq_tx, and clear on accept or in IDLE.
REQ-030 stall SHALL be 1 when stall_cnt >= STALL_LIMIT and SHALL clear on the cycle after accept.

Reset
REQ-031 reset_n=0 at an edge SHALL force: state IDLE, ptr=0, all full_k=0, out_word=0, word_count=0, stall_cnt=0, overflow=0.
REQ-032 During and after reset, outputs SHALL read: RDY_enq_tx=0, enq_tx=0, req_RDY_k=1, stall=0.
REQ-033 Reset in HOLD SHALL discard the offered word and any slot contents, with no accept counted.
REQ-034 Reset SHALL take priority over simultaneous req_EN_k and EN_enq_tx.

Verification
REQ-035 Single word: link_up=1, req_EN_2 with 0x0ABCDEF -> after 2 edges RDY_enq_tx=1, enq_tx=0xC0ABCDEF; EN_enq_tx pulse -> word_count=1, RDY_enq_tx=0.
REQ-036 Round-robin fairness: all four slots full, ptr=0, EN_enq_tx every 8 cycles -> source IDs in enq_tx[30:29] follow 0,1,2,3; refill all -> 0,1,2,3 again.
REQ-037 Overflow: req_EN_1 twice before grant with link_up=0 -> overflow=4'b0010; slot holds the first data; after link_up=1 only the first word is sent.
REQ-038 Link drop: in HOLD, link_up=0 for 20 cycles then 1 -> RDY_enq_tx low throughout the drop; the same enq_tx is re-offered; word_count unchanged until accept.
REQ-039 Stall and wrap: STALL_LIMIT=4, no EN_enq_tx -> stall=1 after 4 RDY cycles and clears after accept; word_count preset to 0xFFFF plus one accept -> 0x0000.
REQ-040 Reset mid-HOLD: reset_n=0 for 1 edge -> all REQ-032 values hold next cycle, and ptr=0 (next grant goes to slot 0 first).
